// File: rtl/send_question_if.sv
// send_question_if: question request fields, link controls and response-window handshake.
interface send_question_if;
    logic       swiptAlive;
    logic [1:0] prog;
    logic       start;
    logic [1:0] mode;
    logic [1:0] ftype;
    logic [7:0] payload;
    logic       dataInReady;
    logic       dout;
    logic       readDataIn;
    logic       busy;
    logic       rxDone;
    logic       timeout;
    modport master (
        output swiptAlive, prog, start, mode, ftype, payload, dataInReady,
        input  dout, readDataIn, busy, rxDone, timeout
    );
    modport slave (
        input  swiptAlive, prog, start, mode, ftype, payload, dataInReady,
        output dout, readDataIn, busy, rxDone, timeout
    );
endinterface

// File: rtl/send_question.sv
// send_question: serialises an 18-bit question frame, guards one bit, then opens a response window.
// Optional SEND_QUESTION_RETRY_EN resends the latched frame once before reporting a timeout.
module send_question #(
    parameter int BIT_PERIOD   = 200000,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic           clk,
    input  logic           rst,
    send_question_if.slave q
);
    localparam int CW = $clog2(BIT_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT_BITS * BIT_PERIOD + 1);
    localparam logic [CW-1:0] BP_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS * BIT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SEND, GUARD, LISTEN} state_t;

    state_t        r_state, w_state;
    logic [17:0]   r_frame, w_frame;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [4:0]    r_bit, w_bit;
    logic [TW-1:0] r_tcnt, w_tcnt;
    logic          r_retry, w_retry;
    logic          r_dout, w_dout;
    logic          r_rdi, w_rdi;
    logic          r_rx, w_rx;
    logic          r_to, w_to;
    logic          r_busy;
    logic          w_ok;
    logic [11:0]   w_fields;

    assign w_fields = {q.mode, q.ftype, q.payload};
    assign w_ok     = q.swiptAlive && (q.prog == 2'b11);

    always_comb begin
        w_state = r_state;
        w_frame = r_frame;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_tcnt  = r_tcnt;
        w_retry = r_retry;
        w_dout  = r_dout;
        w_rdi   = r_rdi;
        w_rx    = 1'b0;
        w_to    = 1'b0;
        if (!w_ok) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_bit   = '0;
            w_tcnt  = '0;
            w_retry = 1'b0;
            w_dout  = 1'b0;
            w_rdi   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_retry = 1'b0;
                    if (q.start) begin
                        w_state = SEND;
                        w_frame = {1'b1, w_fields, 4'($countones(w_fields)), 1'b0};
                        w_cnt   = BP_LAST;
                        w_bit   = 5'd17;
                        w_dout  = 1'b1;
                    end
                end
                SEND: begin
                    if (r_cnt != '0) begin
                        w_cnt = r_cnt - 1'b1;
                    end else if (r_bit != '0) begin
                        w_bit  = r_bit - 5'd1;
                        w_cnt  = BP_LAST;
                        w_dout = r_frame[r_bit - 5'd1];
                    end else begin
                        w_state = GUARD;
                        w_cnt   = BP_LAST;
                        w_dout  = 1'b0;
                    end
                end
                GUARD: begin
                    if (r_cnt != '0) begin
                        w_cnt = r_cnt - 1'b1;
                    end else begin
                        w_state = LISTEN;
                        w_tcnt  = TO_LAST;
                        w_rdi   = 1'b1;
                    end
                end
                LISTEN: begin
                    // a response in the expiry cycle still counts as a response
                    if (q.dataInReady) begin
                        w_state = IDLE;
                        w_rx    = 1'b1;
                        w_rdi   = 1'b0;
                        w_tcnt  = '0;
                        w_retry = 1'b0;
                    end else if (r_tcnt != '0) begin
                        w_tcnt = r_tcnt - 1'b1;
                    end else begin
`ifdef SEND_QUESTION_RETRY_EN
                        w_retry = !r_retry;
`else
                        w_retry = 1'b0;
`endif
                        w_state = w_retry ? SEND : IDLE;
                        w_to    = !w_retry;
                        w_rdi   = 1'b0;
                        w_tcnt  = '0;
                        w_cnt   = w_retry ? BP_LAST : '0;
                        w_bit   = w_retry ? 5'd17 : 5'd0;
                        w_dout  = w_retry;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tcnt  <= '0;
            r_retry <= 1'b0;
            r_dout  <= 1'b0;
            r_rdi   <= 1'b0;
            r_rx    <= 1'b0;
            r_to    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_frame <= w_frame;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_tcnt  <= w_tcnt;
            r_retry <= w_retry;
            r_dout  <= w_dout;
            r_rdi   <= w_rdi;
            r_rx    <= w_rx;
            r_to    <= w_to;
            r_busy  <= (w_state != IDLE);
        end
    end

    assign q.dout       = r_dout;
    assign q.readDataIn = r_rdi;
    assign q.busy       = r_busy;
    assign q.rxDone     = r_rx;
    assign q.timeout    = r_to;
endmodule

// File: tb/tb_send_question.sv
// tb_send_question: directed checks of framing, response window, timeout, abort and reset with BIT_PERIOD=4, TIMEOUT_BITS=3.
module tb_send_question;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    send_question_if q ();

    send_question #(.BIT_PERIOD(4), .TIMEOUT_BITS(3)) dut (
        .clk(clk),
        .rst(rst),
        .q(q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [1:0] t, input logic [7:0] p);
        q.mode = m;
        q.ftype = t;
        q.payload = p;
        q.start = 1'b1;
        tick();
        q.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick_n(2);
        total++;
        if ({q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_init got=%b exp=00000", {q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout});
        end
        rst = 1'b0;
        start_frame(2'b01, 2'b10, 8'h0F);
        tick_n(10);
        total++;
        if (q.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_send got=%b exp=1", q.busy);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_send got=%b exp=00000", {q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout});
        end
        rst = 1'b0;
        q.start = 1'b1;
        tick();
        q.start = 1'b0;
        total++;
        if ({q.busy, q.dout} !== 2'b11) begin
            bad++;
            $display("FAIL accept_after_reset got=%b exp=11", {q.busy, q.dout});
        end
        q.swiptAlive = 1'b0;
        tick();
        q.swiptAlive = 1'b1;
    endtask

    task automatic test_frame_response;
        logic [17:0] f;
        f = 18'b100011010010101010;
        start_frame(2'b00, 2'b01, 8'hA5);
        for (int k = 17; k >= 0; k--) begin
            for (int c = 0; c < 4; c++) begin
                total++;
                if ({q.dout, q.busy, q.readDataIn} !== {f[k], 2'b10}) begin
                    bad++;
                    $display("FAIL frame_bit%0d_c%0d got=%b exp=%b", k, c, {q.dout, q.busy, q.readDataIn}, {f[k], 2'b10});
                end
                tick();
            end
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({q.dout, q.busy, q.readDataIn} !== 3'b010) begin
                bad++;
                $display("FAIL guard_c%0d got=%b exp=010", c, {q.dout, q.busy, q.readDataIn});
            end
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if ({q.readDataIn, q.rxDone, q.timeout} !== 3'b100) begin
                bad++;
                $display("FAIL listen_c%0d got=%b exp=100", c, {q.readDataIn, q.rxDone, q.timeout});
            end
            if (c < 5) tick();
        end
        q.dataInReady = 1'b1;
        tick();
        q.dataInReady = 1'b0;
        total++;
        if ({q.rxDone, q.timeout, q.readDataIn, q.busy} !== 4'b1000) begin
            bad++;
            $display("FAIL response got=%b exp=1000", {q.rxDone, q.timeout, q.readDataIn, q.busy});
        end
        tick();
        total++;
        if ({q.rxDone, q.timeout} !== 2'b00) begin
            bad++;
            $display("FAIL rxdone_one_cycle got=%b exp=00", {q.rxDone, q.timeout});
        end
    endtask

    task automatic test_timeout;
        logic [17:0] f;
        f = 18'b111100011110001110;
        start_frame(2'b11, 2'b10, 8'h3C);
`ifdef SEND_QUESTION_RETRY_EN
        for (int a = 0; a < 2; a++) begin
`else
        for (int a = 0; a < 1; a++) begin
`endif
            for (int k = 17; k >= 0; k--) begin
                for (int c = 0; c < 4; c++) begin
                    total++;
                    if ({q.dout, q.readDataIn} !== {f[k], 1'b0}) begin
                        bad++;
                        $display("FAIL to_frame_a%0d_bit%0d got=%b exp=%b", a, k, {q.dout, q.readDataIn}, {f[k], 1'b0});
                    end
                    tick();
                end
            end
            tick_n(4);
            for (int c = 0; c < 12; c++) begin
                total++;
                if ({q.readDataIn, q.timeout, q.busy} !== 3'b101) begin
                    bad++;
                    $display("FAIL window_a%0d_c%0d got=%b exp=101", a, c, {q.readDataIn, q.timeout, q.busy});
                end
                tick();
            end
        end
        total++;
        if ({q.timeout, q.rxDone, q.readDataIn, q.busy} !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_pulse got=%b exp=1000", {q.timeout, q.rxDone, q.readDataIn, q.busy});
        end
        tick();
        total++;
        if (q.timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_one_cycle got=%b exp=0", q.timeout);
        end
    endtask

    task automatic test_abort;
        start_frame(2'b10, 2'b01, 8'h81);
        tick_n(79);
        total++;
        if (q.readDataIn !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre_listen got=%b exp=1", q.readDataIn);
        end
        q.swiptAlive = 1'b0;
        tick();
        q.swiptAlive = 1'b1;
        total++;
        if ({q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout} !== 5'b0) begin
            bad++;
            $display("FAIL abort_listen got=%b exp=00000", {q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout});
        end
        for (int c = 0; c < 15; c++) begin
            total++;
            if ({q.busy, q.timeout, q.rxDone} !== 3'b000) begin
                bad++;
                $display("FAIL abort_quiet_c%0d got=%b exp=000", c, {q.busy, q.timeout, q.rxDone});
            end
            tick();
        end
        start_frame(2'b01, 2'b01, 8'hF0);
        tick_n(20);
        q.prog = 2'b10;
        tick();
        total++;
        if ({q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout} !== 5'b0) begin
            bad++;
            $display("FAIL abort_send got=%b exp=00000", {q.dout, q.readDataIn, q.busy, q.rxDone, q.timeout});
        end
        q.start = 1'b1;
        tick();
        q.start = 1'b0;
        total++;
        if (q.busy !== 1'b0) begin
            bad++;
            $display("FAIL start_bad_program got=%b exp=0", q.busy);
        end
        q.prog = 2'b11;
        tick();
    endtask

    task automatic test_collision;
        start_frame(2'b00, 2'b00, 8'h00);
        tick_n(87);
        total++;
        if ({q.readDataIn, q.timeout} !== 2'b10) begin
            bad++;
            $display("FAIL pre_expiry got=%b exp=10", {q.readDataIn, q.timeout});
        end
        q.dataInReady = 1'b1;
        tick();
        q.dataInReady = 1'b0;
        total++;
        if ({q.rxDone, q.timeout, q.readDataIn, q.busy} !== 4'b1000) begin
            bad++;
            $display("FAIL collision got=%b exp=1000", {q.rxDone, q.timeout, q.readDataIn, q.busy});
        end
        tick();
        total++;
        if ({q.rxDone, q.timeout} !== 2'b00) begin
            bad++;
            $display("FAIL collision_after got=%b exp=00", {q.rxDone, q.timeout});
        end
    endtask

    task automatic test_start_ignored;
        logic [17:0] f;
        f = 18'b111111111111111000;
        start_frame(2'b11, 2'b11, 8'hFF);
        for (int k = 17; k >= 0; k--) begin
            for (int c = 0; c < 4; c++) begin
                total++;
                if ({q.dout, q.busy, q.rxDone} !== {f[k], 2'b10}) begin
                    bad++;
                    $display("FAIL ign_bit%0d_c%0d got=%b exp=%b", k, c, {q.dout, q.busy, q.rxDone}, {f[k], 2'b10});
                end
                if (k == 15 && c == 1) begin
                    q.mode = 2'b00;
                    q.ftype = 2'b00;
                    q.payload = 8'h00;
                    q.start = 1'b1;
                    q.dataInReady = 1'b1;
                end else begin
                    q.start = 1'b0;
                    q.dataInReady = 1'b0;
                end
                tick();
            end
        end
        q.swiptAlive = 1'b0;
        tick();
        q.swiptAlive = 1'b1;
        total++;
        if (q.busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_cleanup got=%b exp=0", q.busy);
        end
    endtask

    initial begin
        q.swiptAlive = 1'b1;
        q.prog = 2'b11;
        q.start = 1'b0;
        q.mode = 2'b00;
        q.ftype = 2'b00;
        q.payload = 8'h00;
        q.dataInReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame_response();
        test_timeout();
        test_abort();
        test_collision();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/send_question.md
# send_question

Bit-serial frame transmitter and response-window controller for the SWIPT data link, sitting directly upstream of the receive analyser. It serialises a {mode, type, payload} question frame onto `dout` at the link bit rate, holds a one-bit guard gap, then drives `readDataIn` high to open the analyser's receive window. The window stays open until the analyser reports `dataInReady` or a timeout expires.

## Interface
Parameters:
- `BIT_PERIOD`, 200000: clock cycles per transmitted bit; must match the analyser's bit period.
- `TIMEOUT_BITS`, 64: response window length, in bit periods.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `swiptAlive` in 1: link alive; low aborts any operation.
- `program` in 2: operation only when `2'b11`; any other value aborts.
- `start` in 1: request a transmission; sampled in IDLE only.
- `mode` in 2: frame mode field; latched at accept.
- `type` in 2: frame type field; latched at accept.
- `payload` in 8: frame payload; latched at accept.
- `dataInReady` in 1: analyser has a complete response.
- `dout` out 1: serial line, MSB first.
- `readDataIn` out 1: receive window enable to the analyser.
- `busy` out 1: high in every state except IDLE.
- `rxDone` out 1: one-cycle pulse when a response arrives.
- `timeout` out 1: one-cycle pulse when the window expires with no response.

## Operation
- Frame is 18 bits, sent MSB first: {1'b1 start, mode[1:0], type[1:0], payload[7:0], ones[3:0], 1'b0 stop}.
- `ones` is the population count of the 12 bits {mode, type, payload}, range 0–12.
- States and transitions:
  - IDLE → SEND: `start` high while `swiptAlive` is high and `program==2'b11`. Fields are latched and the frame register is built in the same cycle.
  - SEND: each bit is held for exactly `BIT_PERIOD` cycles by a down-counter; a bit counter runs 17→0. After bit 0 → GUARD.
  - GUARD: `dout`=0 for `BIT_PERIOD` cycles → LISTEN.
  - LISTEN: `readDataIn`=1 and the timeout counter counts `TIMEOUT_BITS*BIT_PERIOD` cycles.
    - `dataInReady` high → `rxDone` pulse, go to IDLE.
    - Counter expiry → `timeout` pulse, go to IDLE (or RETRY, see Configuration).
- `dataInReady` outside LISTEN is ignored.
- `start` while `busy` is ignored and is not queued.
- Abort: `swiptAlive` low or `program!=2'b11` in any state → IDLE on the next edge. On abort, `dout`=0, `readDataIn`=0, no pulses, and all counters are cleared.
- Counter width is enough for `TIMEOUT_BITS*BIT_PERIOD`; 24 bits minimum at the defaults (12.8M).

## Timing
- Reset values: `dout`=0, `readDataIn`=0, `busy`=0, `rxDone`=0, `timeout`=0, state IDLE, all counters 0.
- All outputs are registered.
- Accept at edge N: `busy`=1 and `dout`=start bit from edge N+1.
- Bit k of the frame (k=17..0) is driven on cycles N+1+(17−k)·BIT_PERIOD through N+(18−k)·BIT_PERIOD.
- GUARD starts at cycle N+1+18·BIT_PERIOD and lasts BIT_PERIOD cycles.
- `readDataIn` rises at N+1+19·BIT_PERIOD.
- `dataInReady` sampled high at edge M in LISTEN:
  - `rxDone`=1 for cycle M+1.
  - `readDataIn`=0 and `busy`=0 from M+1.
- Timeout: `timeout` pulse occurs exactly `TIMEOUT_BITS*BIT_PERIOD` cycles after `readDataIn` rises; `readDataIn` falls in the same cycle as the pulse.
- `dataInReady` in the same cycle as timeout expiry: response wins; `rxDone` pulses and `timeout` does not.
- `rst` has priority over abort, and abort has priority over all state transitions.

## Configuration
- `SEND_QUESTION_RETRY_EN` defined:
  - On the first timeout, no `timeout` pulse is issued.
  - `readDataIn` drops and the block re-enters SEND with the same latched frame, then runs the GUARD and LISTEN phases again.
  - A second timeout issues the `timeout` pulse and returns to IDLE. The retry flag clears on IDLE.
- `SEND_QUESTION_RETRY_EN` undefined: a single attempt; the first expiry pulses `timeout`.

## Test plan
All scenarios use BIT_PERIOD=4 and TIMEOUT_BITS=3.
- Reset: assert `rst` mid-SEND → next cycle all outputs 0 and `busy`=0; `start` accepted on the following cycle.
- Frame: mode=00, type=01, payload=0xA5, `start` pulse → `dout` sequence 1,0,0,0,1,1,0,1,0,0,1,0,1,0,1,0,1,0 (ones=5), each bit 4 cycles, then 4 cycles of 0; `readDataIn` rises 77 cycles after accept.
- Response: `dataInReady` asserted 5 cycles into LISTEN → `rxDone` 1-cycle pulse, `readDataIn` falls the same cycle, no `timeout`.
- Timeout: no `dataInReady` → `timeout` pulse 12 cycles after `readDataIn` rises. With `SEND_QUESTION_RETRY_EN`, the frame is resent and the pulse comes only after the second window.
- Abort: drop `swiptAlive` during LISTEN → next cycle `readDataIn`=0 and `busy`=0, no pulses. Repeat with `program`=2'b10 during SEND → same result.
- Collision and ignore: `dataInReady` coincides with the expiry cycle → `rxDone` only. `start` during SEND → ignored, frame unchanged.
